// File: rtl/serial_receiver_if.sv
// Serial receiver bus: serial line in, deserialized word plus status out.
// master = line driver / word consumer side, slave = the receiver.
interface serial_receiver_if #(
  parameter int DATA_W = 55
);
  logic              S_Data;
  logic              RX_Data_Ack;
  logic [DATA_W-1:0] RX_Data;
  logic              RX_Data_Valid;
  logic              RX_Busy;
  logic              Frame_Err;
  logic              Parity_Err;
  logic              Overrun;

  modport master (
    output S_Data, RX_Data_Ack,
    input  RX_Data, RX_Data_Valid, RX_Busy, Frame_Err, Parity_Err, Overrun
  );

  modport slave (
    input  S_Data, RX_Data_Ack,
    output RX_Data, RX_Data_Valid, RX_Busy, Frame_Err, Parity_Err, Overrun
  );
endinterface

// File: rtl/serial_receiver.sv
// serial_receiver: one-bit-per-clock frame deserializer with valid/ack output.
// Frame: start 0, DATA_W data bits LSB first, [even parity], stop 1.
// Optional feature macro: RX_PARITY_CHECK_EN (parity bit + PAR state + Parity_Err).
module serial_receiver #(
  parameter int DATA_W = 55,
  parameter int CNT_W  = 6
) (
  input logic              clk,
  input logic              rst,
  serial_receiver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, WAIT_IDLE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              ferr_q;
  logic              perr_q;
  logic              ovr_q;
  logic              par_bad;

`ifdef RX_PARITY_CHECK_EN
  logic par_bit;
  // Even parity: data XOR parity bit must be 0.
  assign par_bad = (^shreg) ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  // Frame FSM, shift register, output word/handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
      // Consumer ack; a word loading on the same edge overrides this below.
      if (valid_q && bus.RX_Data_Ack) valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.S_Data) begin
            state  <= DATA;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        DATA: begin
          shreg[cnt] <= bus.S_Data;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
`ifdef RX_PARITY_CHECK_EN
            state <= PAR;
`else
            state <= STOP;
`endif
          end
        end
        PAR: begin
`ifdef RX_PARITY_CHECK_EN
          par_bit <= bus.S_Data;
          state   <= STOP;
`else
          state  <= IDLE;
          busy_q <= 1'b0;
`endif
        end
        STOP: begin
          if (bus.S_Data) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (par_bad) begin
              perr_q <= 1'b1;
            end else if (valid_q && !bus.RX_Data_Ack) begin
              ovr_q <= 1'b1;
            end else begin
              data_q  <= shreg;
              valid_q <= 1'b1;
            end
          end else begin
            // Bad stop bit: drop the frame and wait for the line to idle
            // so we never resync on a data bit.
            ferr_q <= 1'b1;
            state  <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (bus.S_Data) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RX_Data       = data_q;
  assign bus.RX_Data_Valid = valid_q;
  assign bus.RX_Busy       = busy_q;
  assign bus.Frame_Err     = ferr_q;
  assign bus.Parity_Err    = perr_q;
  assign bus.Overrun       = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver; follows RX_PARITY_CHECK_EN like the DUT.
module tb_serial_receiver;

  localparam int DW = 55;
`ifdef RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [DW-1:0] W1 = 55'h12_3456_789A_BCDE;
  localparam logic [DW-1:0] W2 = 55'h1;
  localparam logic [DW-1:0] W3 = 55'h7F_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] W4 = 55'h2A_5A5A_0F0F_3C3C;
  localparam logic [DW-1:0] W5 = 55'h55_AAAA_1234_8001;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;

  serial_receiver_if #(.DATA_W(DW)) bus ();

  serial_receiver #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count every pulse seen so totals can be checked at the end.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.Overrun)    ovr_cnt  <= ovr_cnt + 1;
      if (bus.Frame_Err)  ferr_cnt <= ferr_cnt + 1;
      if (bus.Parity_Err) perr_cnt <= perr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.S_Data = b;
    tick();
  endtask

  // Start bit, data LSB first, parity (flipped on request); no stop bit.
  task automatic send_body(input logic [DW-1:0] d, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ flip);
  endtask

  task automatic send_frame(input logic [DW-1:0] d);
    send_body(d, 1'b0);
    send_bit(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.S_Data = 1'b1;
    bus.RX_Data_Ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("reset_data",  64'(bus.RX_Data), 64'h0);
    check("reset_valid", 64'(bus.RX_Data_Valid), 64'h0);
    check("reset_busy",  64'(bus.RX_Busy), 64'h0);
    check("reset_pulses", 64'({bus.Frame_Err, bus.Parity_Err, bus.Overrun}), 64'h0);

    // Single frame: valid only after the stop edge (57/58 ticks from start).
    send_bit(1'b0);
    check("busy_after_start", 64'(bus.RX_Busy), 64'h1);
    for (int i = 0; i < DW; i++) send_bit(W1[i]);
    if (PAR_EN) send_bit(^W1);
    check("valid_before_stop", 64'(bus.RX_Data_Valid), 64'h0);
    send_bit(1'b1);
    check("w1_valid", 64'(bus.RX_Data_Valid), 64'h1);
    check("w1_data",  64'(bus.RX_Data), 64'(W1));
    check("busy_after_stop", 64'(bus.RX_Busy), 64'h0);
    bus.RX_Data_Ack = 1'b1;
    tick();
    bus.RX_Data_Ack = 1'b0;
    check("ack_clears_valid", 64'(bus.RX_Data_Valid), 64'h0);
    check("data_kept_after_ack", 64'(bus.RX_Data), 64'(W1));

    // Ack while nothing valid is ignored.
    bus.RX_Data_Ack = 1'b1;
    tick();
    check("stray_ack_valid", 64'(bus.RX_Data_Valid), 64'h0);

    // Back-to-back frames with ack held high.
    send_frame(W2);
    check("b2b_w2_valid", 64'(bus.RX_Data_Valid), 64'h1);
    check("b2b_w2_data",  64'(bus.RX_Data), 64'(W2));
    send_frame(W3);
    check("b2b_w3_valid", 64'(bus.RX_Data_Valid), 64'h1);
    check("b2b_w3_data",  64'(bus.RX_Data), 64'(W3));
    check("b2b_no_overrun", 64'(bus.Overrun), 64'h0);
    tick();
    bus.RX_Data_Ack = 1'b0;
    check("b2b_final_ack", 64'(bus.RX_Data_Valid), 64'h0);
    check("b2b_overrun_cnt", 64'(ovr_cnt), 64'h0);

    // Overrun: second good frame while first is unacked.
    send_frame(W4);
    check("ovr_first_data", 64'(bus.RX_Data), 64'(W4));
    send_frame(W5);
    check("ovr_pulse", 64'(bus.Overrun), 64'h1);
    check("ovr_data_kept", 64'(bus.RX_Data), 64'(W4));
    check("ovr_valid_kept", 64'(bus.RX_Data_Valid), 64'h1);
    tick();
    check("ovr_pulse_one_cycle", 64'(bus.Overrun), 64'h0);
    bus.RX_Data_Ack = 1'b1;
    tick();
    bus.RX_Data_Ack = 1'b0;
    check("ovr_acked", 64'(bus.RX_Data_Valid), 64'h0);

    // Frame error: stop bit 0, line held low 5 more cycles.
    send_body(W2, 1'b0);
    send_bit(1'b0);
    check("ferr_pulse", 64'(bus.Frame_Err), 64'h1);
    check("ferr_valid_unchanged", 64'(bus.RX_Data_Valid), 64'h0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    check("ferr_one_cycle", 64'(bus.Frame_Err), 64'h0);
    check("ferr_wait_idle_busy", 64'(bus.RX_Busy), 64'h1);
    send_bit(1'b1);
    check("ferr_back_to_idle", 64'(bus.RX_Busy), 64'h0);
    send_frame(W5);
    check("ferr_next_valid", 64'(bus.RX_Data_Valid), 64'h1);
    check("ferr_next_data",  64'(bus.RX_Data), 64'(W5));
    bus.RX_Data_Ack = 1'b1;
    tick();
    bus.RX_Data_Ack = 1'b0;

    // Parity error (parity build only): frame discarded, valid unchanged.
    if (PAR_EN) begin
      send_body(W3, 1'b1);
      send_bit(1'b1);
      check("perr_pulse", 64'(bus.Parity_Err), 64'h1);
      check("perr_valid_unchanged", 64'(bus.RX_Data_Valid), 64'h0);
      check("perr_data_unchanged", 64'(bus.RX_Data), 64'(W5));
      tick();
      check("perr_one_cycle", 64'(bus.Parity_Err), 64'h0);
    end

    // Reset mid-frame at data bit 20 with a word pending.
    send_frame(W1);
    check("pre_rst_valid", 64'(bus.RX_Data_Valid), 64'h1);
    send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(W2[i]);
    rst = 1'b1;
    bus.S_Data = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", 64'(bus.RX_Data_Valid), 64'h0);
    check("rst_data",  64'(bus.RX_Data), 64'h0);
    check("rst_busy",  64'(bus.RX_Busy), 64'h0);
    check("rst_pulses", 64'({bus.Frame_Err, bus.Parity_Err, bus.Overrun}), 64'h0);
    tick();
    send_frame(W4);
    check("post_rst_valid", 64'(bus.RX_Data_Valid), 64'h1);
    check("post_rst_data",  64'(bus.RX_Data), 64'(W4));
    tick();
    tick();

    check("total_overrun", 64'(ovr_cnt), 64'h1);
    check("total_frame_err", 64'(ferr_cnt), 64'h1);
    check("total_parity_err", 64'(perr_cnt), 64'(PAR_EN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
